// File: rtl/divisor_mantiza.sv
// rtl/divisor_mantiza.sv - bit-serial restoring divider for (1.m1)/(1.m2), normalized quotient fraction
// Optional round-to-nearest (ties up) with an extra guard bit: DIVISOR_MANTIZA_REDONDEO_EN
module divisor_mantiza #(
    parameter int NB_MANT = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [NB_MANT-1:0] i_mantiza_1,
    input  logic [NB_MANT-1:0] i_mantiza_2,
    output logic [NB_MANT-1:0] o_mantiza,
    output logic               o_ajuste_exp,
    output logic               o_valid,
    output logic               o_busy
);

`ifdef DIVISOR_MANTIZA_REDONDEO_EN
    localparam int N_IT = NB_MANT + 3;
`else
    localparam int N_IT = NB_MANT + 2;
`endif
    localparam int NB_CNT = $clog2(N_IT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [NB_MANT:0]    div_b;
    logic [NB_MANT+1:0]  rem_r;
    logic [NB_MANT+1:0]  rem_diff;
    logic [NB_MANT+1:0]  rem_sel;
    logic                q_bit;
    logic [N_IT-1:0]     quo;
    logic [NB_CNT-1:0]   cnt;
    logic                int_bit;
    logic [NB_MANT-1:0]  res_mant;
    logic                res_aj;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start) state_next = DIVIDE;
            DIVIDE:  if (cnt == NB_CNT'(N_IT - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign o_busy = (state == DIVIDE);

    // Remainder stays below 2*B, so NB_MANT+2 bits never overflow after the shift.
    assign q_bit    = (rem_r >= {1'b0, div_b});
    assign rem_diff = rem_r - {1'b0, div_b};
    assign rem_sel  = q_bit ? rem_diff : rem_r;
    assign int_bit  = quo[N_IT-1];

`ifdef DIVISOR_MANTIZA_REDONDEO_EN
    logic [NB_MANT-1:0] frac_sel;
    logic               guard;
    logic [NB_MANT:0]   frac_rnd;

    always_comb begin
        frac_sel = int_bit ? quo[NB_MANT+1:2] : quo[NB_MANT:1];
        guard    = int_bit ? quo[1] : quo[0];
        frac_rnd = {1'b0, frac_sel} + {{NB_MANT{1'b0}}, guard};
        res_mant = frac_rnd[NB_MANT-1:0];
        res_aj   = ~int_bit;
        // Rounding a sub-1.0 quotient all the way up lands exactly on 1.0.
        if (!int_bit && frac_rnd[NB_MANT]) begin
            res_mant = '0;
            res_aj   = 1'b0;
        end
    end
`else
    always_comb begin
        res_mant = int_bit ? quo[NB_MANT:1] : quo[NB_MANT-1:0];
        res_aj   = ~int_bit;
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            div_b        <= '0;
            rem_r        <= '0;
            quo          <= '0;
            cnt          <= '0;
            o_mantiza    <= '0;
            o_ajuste_exp <= 1'b0;
            o_valid      <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        div_b <= {1'b1, i_mantiza_2};
                        rem_r <= {2'b01, i_mantiza_1};
                        quo   <= '0;
                        cnt   <= '0;
                    end
                end
                DIVIDE: begin
                    rem_r <= rem_sel << 1;
                    quo   <= {quo[N_IT-2:0], q_bit};
                    cnt   <= cnt + 1'b1;
                end
                DONE: begin
                    o_mantiza    <= res_mant;
                    o_ajuste_exp <= res_aj;
                    o_valid      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
